// File: rtl/sram_arbiter_pkg.sv
// Shared types and constants for the SRAM arbiter: state encodings, the
// address/data widths, and the round-robin pick function.
package sram_arbiter_pkg;

  localparam int ADDRESS_LEN   = 32;
  localparam int REGISTER_LEN  = 32;
  localparam int SRAM_LINE_LEN = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  // Returns the index of the winning port. If only one port is requesting,
  // that port wins. If both are requesting, the port that was not served
  // last wins, so two busy requesters alternate.
  function automatic logic rr_pick(input logic req0, input logic req1,
                                   input logic last_grant);
    logic win;
    if (req0 && req1) begin
      win = ~last_grant;
    end else begin
      win = req1;
    end
    return win;
  endfunction

endpackage

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter in front of a single SRAM controller.
// The owner's address, store data and operation are captured when the grant
// is made. The SRAM's completion pulse and read line are steered only to the
// owning port. A one-cycle DONE gap keeps the enables low so the controller
// can return to idle between transfers.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDRESS_LEN,
  parameter int WDATA_W = REGISTER_LEN,
  parameter int RDATA_W = SRAM_LINE_LEN
) (
  input  logic               clk,
  input  logic               rst,
  // port 0: data cache
  input  logic               p0_read_en,
  input  logic               p0_write_en,
  input  logic [ADDR_W-1:0]  p0_addr,
  input  logic [WDATA_W-1:0] p0_st_val,
  output logic [RDATA_W-1:0] p0_read_data,
  output logic               p0_ready,
  // port 1: instruction fetch
  input  logic               p1_read_en,
  input  logic               p1_write_en,
  input  logic [ADDR_W-1:0]  p1_addr,
  input  logic [WDATA_W-1:0] p1_st_val,
  output logic [RDATA_W-1:0] p1_read_data,
  output logic               p1_ready,
  // SRAM controller side
  output logic               sram_read_en,
  output logic               sram_write_en,
  output logic [ADDR_W-1:0]  sram_addr,
  output logic [WDATA_W-1:0] sram_st_val,
  input  logic [RDATA_W-1:0] sram_read_data,
  input  logic               sram_ready,
  output logic               busy
);

  arb_state_e         state_q, state_d;
  logic               last_grant_q, last_grant_d;
  logic               gnt_q, gnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [WDATA_W-1:0] st_val_q, st_val_d;
  logic               op_write_q, op_write_d;

  logic req0, req1, win;

  assign req0 = p0_read_en | p0_write_en;
  assign req1 = p1_read_en | p1_write_en;

  // State and latched-request registers. On reset, last_grant goes to 1 so
  // that port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      addr_q       <= '0;
      st_val_q     <= '0;
      op_write_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      addr_q       <= addr_d;
      st_val_q     <= st_val_d;
      op_write_q   <= op_write_d;
    end
  end

  // Next-state logic. In IDLE it arbitrates and captures the winner's
  // request. In BUSY it waits for SRAM completion. DONE always returns to
  // IDLE, and any request seen in DONE is ignored.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    addr_d       = addr_q;
    st_val_d     = st_val_q;
    op_write_d   = op_write_q;
    win          = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (req0 || req1) begin
          win        = rr_pick(req0, req1, last_grant_q);
          gnt_d      = win;
          addr_d     = win ? p1_addr : p0_addr;
          st_val_d   = win ? p1_st_val : p0_st_val;
          // If read and write are both asserted, the operation is a write.
          op_write_d = win ? p1_write_en : p0_write_en;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (sram_ready) begin
          last_grant_d = gnt_q;
          state_d      = ARB_DONE;
        end
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // Output logic. The enables follow the latched operation only while BUSY.
  // The completion pulse and read line pass through combinationally to the
  // owning port and nowhere else.
  always_comb begin
    sram_read_en  = 1'b0;
    sram_write_en = 1'b0;
    sram_addr     = addr_q;
    sram_st_val   = st_val_q;
    p0_ready      = 1'b0;
    p1_ready      = 1'b0;
    p0_read_data  = '0;
    p1_read_data  = '0;
    busy          = (state_q != ARB_IDLE);
    if (state_q == ARB_BUSY) begin
      sram_read_en  = ~op_write_q;
      sram_write_en = op_write_q;
      if (sram_ready) begin
        if (gnt_q) begin
          p1_ready     = 1'b1;
          p1_read_data = sram_read_data;
        end else begin
          p0_ready     = 1'b1;
          p0_read_data = sram_read_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter. It contains a behavioural SRAM with a fixed
// 5-cycle latency, a table of single- and dual-port transfers, and
// hand-written sequences for back-to-back alternation and reset in the
// middle of a transfer.
module tb_sram_arbiter;

  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        p0_read_en, p0_write_en, p1_read_en, p1_write_en;
  logic [31:0] p0_addr, p0_st_val, p1_addr, p1_st_val;
  logic [63:0] p0_read_data, p1_read_data;
  logic        p0_ready, p1_ready;
  logic        sram_read_en, sram_write_en;
  logic [31:0] sram_addr, sram_st_val;
  logic [63:0] sram_read_data;
  logic        sram_ready;
  logic        busy;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sram_arbiter dut (
    .clk           (clk),
    .rst           (rst),
    .p0_read_en    (p0_read_en),
    .p0_write_en   (p0_write_en),
    .p0_addr       (p0_addr),
    .p0_st_val     (p0_st_val),
    .p0_read_data  (p0_read_data),
    .p0_ready      (p0_ready),
    .p1_read_en    (p1_read_en),
    .p1_write_en   (p1_write_en),
    .p1_addr       (p1_addr),
    .p1_st_val     (p1_st_val),
    .p1_read_data  (p1_read_data),
    .p1_ready      (p1_ready),
    .sram_read_en  (sram_read_en),
    .sram_write_en (sram_write_en),
    .sram_addr     (sram_addr),
    .sram_st_val   (sram_st_val),
    .sram_read_data(sram_read_data),
    .sram_ready    (sram_ready),
    .busy          (busy)
  );

  // Behavioural SRAM. Word memory; a line is the two words of an 8-byte block.
  logic [31:0] mem [0:1023];
  logic        mem_clear;
  logic        sram_any;
  int          cnt;

  assign sram_any = sram_read_en | sram_write_en;

  function automatic logic [63:0] line_of(input logic [31:0] a);
    return {mem[{a[11:3], 1'b1}], mem[{a[11:3], 1'b0}]};
  endfunction

  always @(posedge clk) begin
    if (!sram_any) cnt <= 0;
    else           cnt <= cnt + 1;
  end

  assign sram_ready     = sram_any && (cnt == LAT - 1);
  assign sram_read_data = sram_ready ? line_of(sram_addr) : 64'hBADD_F00D_BADD_F00D;

  always @(posedge clk) begin
    if (mem_clear) begin
      for (int i = 0; i < 1024; i++) mem[i] <= {16'hC0DE, 6'd0, 10'(i)};
    end else if (sram_ready && sram_write_en) begin
      mem[sram_addr[11:2]] <= sram_st_val;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_req();
    p0_read_en = 0; p0_write_en = 0; p0_addr = '0; p0_st_val = '0;
    p1_read_en = 0; p1_write_en = 0; p1_addr = '0; p1_st_val = '0;
  endtask

  typedef struct {
    bit          do_rst;
    logic        p0_rd, p0_wr;
    logic [31:0] p0_addr, p0_st;
    logic        p1_rd, p1_wr;
    logic [31:0] p1_addr, p1_st;
    int          first;
    int          second;
  } vec_t;

  vec_t vecs[8];

  // Applies one vector and follows it until every requesting port has been
  // served. It checks service order, latency, the SRAM-side drive, and the
  // routed data, then checks the DONE gap and the return to IDLE.
  task automatic run_vec(input int idx, input vec_t v);
    logic [1:0]  pend;
    int          k, port;
    bit          prev_ready;
    logic        exp_wr;
    logic [31:0] exp_addr, exp_st;
    if (v.do_rst) begin
      @(negedge clk); rst = 1;
      @(negedge clk); rst = 0;
    end
    @(negedge clk);
    p0_read_en = v.p0_rd; p0_write_en = v.p0_wr; p0_addr = v.p0_addr; p0_st_val = v.p0_st;
    p1_read_en = v.p1_rd; p1_write_en = v.p1_wr; p1_addr = v.p1_addr; p1_st_val = v.p1_st;
    pend = {v.p1_rd | v.p1_wr, v.p0_rd | v.p0_wr};
    k = 0;
    prev_ready = 0;
    for (int n = 1; n <= 80 && pend != 2'b00; n++) begin
      @(negedge clk);
      if (prev_ready) begin
        check("gap_en", 64'(sram_any), 64'(0));
        check("gap_busy", 64'(busy), 64'(1));
      end
      prev_ready = 0;
      if (p0_ready || p1_ready) begin
        check("one_ready", 64'(p0_ready && p1_ready), 64'(0));
        port     = p1_ready ? 1 : 0;
        exp_wr   = port == 1 ? v.p1_wr   : v.p0_wr;
        exp_addr = port == 1 ? v.p1_addr : v.p0_addr;
        exp_st   = port == 1 ? v.p1_st   : v.p0_st;
        check("order", 64'(port), 64'(k == 0 ? v.first : v.second));
        check("latency", 64'(n), 64'(k == 0 ? 5 : 12));
        check("sram_write_en", 64'(sram_write_en), 64'(exp_wr));
        check("sram_read_en", 64'(sram_read_en), 64'(!exp_wr));
        check("sram_addr", 64'(sram_addr), 64'(exp_addr));
        if (exp_wr) check("sram_st_val", 64'(sram_st_val), 64'(exp_st));
        else check("rdata", port == 1 ? p1_read_data : p0_read_data, line_of(exp_addr));
        check("other_rdata", port == 1 ? p0_read_data : p1_read_data, 64'(0));
        $display("[TB] vec %0d xfer port=%0d %s addr=0x%08h cycle=%0d data=0x%016h",
                 idx, port, exp_wr ? "WR" : "RD", exp_addr, n,
                 port == 1 ? p1_read_data : p0_read_data);
        if (port == 1) begin p1_read_en = 0; p1_write_en = 0; end
        else           begin p0_read_en = 0; p0_write_en = 0; end
        pend[port] = 1'b0;
        k++;
        prev_ready = 1;
      end
    end
    if (pend != 2'b00) begin
      tests++; fails++;
      $display("FAIL timeout vec %0d: pending=%b, required 00", idx, pend);
    end else begin
      @(negedge clk);
      check("done_en", 64'(sram_any), 64'(0));
      check("done_busy", 64'(busy), 64'(1));
      @(negedge clk);
      check("idle_busy", 64'(busy), 64'(0));
      if (v.p0_wr) check("mem_p0", 64'(mem[v.p0_addr[11:2]]), 64'(v.p0_st));
      if (v.p1_wr) check("mem_p1", 64'(mem[v.p1_addr[11:2]]), 64'(v.p1_st));
    end
  endtask

  initial begin
    logic [31:0] a0 [3];
    logic [31:0] a1 [3];
    int          i0, i1, k, port;
    bit          re0, re1;
    vec_t        vb;

    // Expected order assumes last_grant carries over between vectors.
    vecs[0] = '{do_rst:0, p0_rd:1, p0_wr:0, p0_addr:32'h100, p0_st:0,
                p1_rd:0, p1_wr:0, p1_addr:0, p1_st:0, first:0, second:-1};
    vecs[1] = '{do_rst:0, p0_rd:0, p0_wr:0, p0_addr:0, p0_st:0,
                p1_rd:0, p1_wr:1, p1_addr:32'h40, p1_st:32'hDEAD_BEEF, first:1, second:-1};
    vecs[2] = '{do_rst:1, p0_rd:1, p0_wr:0, p0_addr:32'h200, p0_st:0,
                p1_rd:1, p1_wr:0, p1_addr:32'h300, p1_st:0, first:0, second:1};
    vecs[3] = '{do_rst:0, p0_rd:1, p0_wr:1, p0_addr:32'h8, p0_st:32'h1234,
                p1_rd:0, p1_wr:0, p1_addr:0, p1_st:0, first:0, second:-1};
    vecs[4] = '{do_rst:0, p0_rd:1, p0_wr:0, p0_addr:32'h80, p0_st:0,
                p1_rd:1, p1_wr:0, p1_addr:32'h88, p1_st:0, first:1, second:0};
    vecs[5] = '{do_rst:0, p0_rd:0, p0_wr:1, p0_addr:32'h10, p0_st:32'h1111_2222,
                p1_rd:0, p1_wr:1, p1_addr:32'h14, p1_st:32'h3333_4444, first:1, second:0};
    vecs[6] = '{do_rst:0, p0_rd:0, p0_wr:0, p0_addr:0, p0_st:0,
                p1_rd:1, p1_wr:0, p1_addr:32'h40, p1_st:0, first:1, second:-1};
    vecs[7] = '{do_rst:0, p0_rd:1, p0_wr:0, p0_addr:32'h10, p0_st:0,
                p1_rd:0, p1_wr:0, p1_addr:0, p1_st:0, first:0, second:-1};

    clear_req();
    rst = 1;
    mem_clear = 1;
    repeat (3) @(negedge clk);
    mem_clear = 0;
    rst = 0;
    @(negedge clk);
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_en", 64'({sram_read_en, sram_write_en}), 64'(0));
    check("rst_addr", 64'(sram_addr), 64'(0));
    check("rst_st_val", 64'(sram_st_val), 64'(0));
    check("rst_ready", 64'({p0_ready, p1_ready}), 64'(0));
    check("rst_rdata", p0_read_data | p1_read_data, 64'(0));

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Hand-computed memory contents after the table's writes.
    check("mem_0x40", 64'(mem[16]), 64'h0000_0000_DEAD_BEEF);
    check("mem_0x8", 64'(mem[2]), 64'h0000_0000_0000_1234);
    check("mem_0x14", 64'(mem[5]), 64'h0000_0000_3333_4444);

    // Back-to-back: both ports keep requesting. Each port re-requests in the
    // DONE cycle after its own ready, so service alternates 0,1,0,1,0,1, with
    // a ready every 7 cycles after the first.
    a0 = '{32'h400, 32'h408, 32'h410};
    a1 = '{32'h500, 32'h508, 32'h510};
    @(negedge clk); rst = 1;
    @(negedge clk); rst = 0;
    @(negedge clk);
    p0_read_en = 1; p0_addr = a0[0];
    p1_read_en = 1; p1_addr = a1[0];
    i0 = 0; i1 = 0; k = 0; re0 = 0; re1 = 0;
    for (int n = 1; n <= 200 && k < 6; n++) begin
      @(negedge clk);
      if (re0) begin p0_read_en = 1; p0_addr = a0[i0]; re0 = 0; end
      if (re1) begin p1_read_en = 1; p1_addr = a1[i1]; re1 = 0; end
      if (p0_ready || p1_ready) begin
        port = p1_ready ? 1 : 0;
        check("b2b_order", 64'(port), 64'(k % 2));
        check("b2b_latency", 64'(n), 64'(5 + 7 * k));
        if (port == 1) begin
          check("b2b_rdata1", p1_read_data, line_of(a1[i1]));
          $display("[TB] b2b xfer %0d port=1 addr=0x%08h cycle=%0d", k, a1[i1], n);
          p1_read_en = 0; i1++; re1 = (i1 < 3);
        end else begin
          check("b2b_rdata0", p0_read_data, line_of(a0[i0]));
          $display("[TB] b2b xfer %0d port=0 addr=0x%08h cycle=%0d", k, a0[i0], n);
          p0_read_en = 0; i0++; re0 = (i0 < 3);
        end
        k++;
      end
    end
    if (k < 6) begin
      tests++; fails++;
      $display("FAIL b2b_timeout: got %0d transfers, required 6", k);
    end
    clear_req();
    repeat (3) @(negedge clk);

    // Reset during BUSY. First serve port 0 alone so last_grant is 0. Then
    // abort a port-1 read 2 cycles into BUSY. The following tie must go to
    // port 0, which shows that reset restored last_grant to 1.
    vb = '{do_rst:0, p0_rd:1, p0_wr:0, p0_addr:32'h600, p0_st:0,
           p1_rd:0, p1_wr:0, p1_addr:0, p1_st:0, first:0, second:-1};
    run_vec(8, vb);
    @(negedge clk);
    p1_read_en = 1; p1_addr = 32'h700;
    @(negedge clk);
    check("abort_en_busy", 64'(sram_read_en), 64'(1));
    @(negedge clk);
    check("abort_no_ready", 64'({p0_ready, p1_ready}), 64'(0));
    rst = 1;
    clear_req();
    @(negedge clk);
    check("abort_en", 64'({sram_read_en, sram_write_en}), 64'(0));
    check("abort_ready", 64'({p0_ready, p1_ready}), 64'(0));
    check("abort_idle", 64'(busy), 64'(0));
    $display("[TB] abort port=1 addr=0x00000700 by reset");
    rst = 0;
    vb = '{do_rst:0, p0_rd:1, p0_wr:0, p0_addr:32'h680, p0_st:0,
           p1_rd:1, p1_wr:0, p1_addr:32'h780, p1_st:0, first:0, second:1};
    run_vec(9, vb);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
